// File: rtl/keyboard_fifo_producer_pkg.sv
// rtl/keyboard_fifo_producer_pkg.sv - shared types for the keyboard-to-UART FIFO entry format
package keyboard_fifo_producer_pkg;

    // Deepest sequence one FIFO entry can carry (escape sequences, UTF-8).
    localparam int UART_FIFO_MAX_CHARS = 7;

    typedef logic [7:0] UartData_t;

    // chars[7] is the most significant slot; the drain side sends
    // chars[length] first, down to chars[1].
    typedef struct packed {
        logic [2:0]                          length;
        UartData_t [UART_FIFO_MAX_CHARS:1]   chars;
    } UartFifoData_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUSH    = 2'd2
    } ProducerState_t;

endpackage

// File: rtl/keyboard_fifo_producer.sv
// rtl/keyboard_fifo_producer.sv - packs a ready/valid byte stream into one FIFO entry per sequence
module keyboard_fifo_producer
    import keyboard_fifo_producer_pkg::*;
#(
    parameter int FLUSH_TIMEOUT = 0,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    input  logic        i_byte_last,
    output logic        o_byte_ready,
    input  logic        i_fifo_full,
    output logic        o_fifo_write_request,
    output logic [58:0] o_fifo_in_data,
    output logic        o_busy
);

    // Count value at which the incoming byte fills the final slot.
    localparam logic [2:0] LAST_SLOT = 3'(UART_FIFO_MAX_CHARS - 1);
    // Idle count at which a partial entry is flushed (unused when disabled).
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
        TIMEOUT_WIDTH'((FLUSH_TIMEOUT > 0) ? (FLUSH_TIMEOUT - 1) : 0);
    localparam logic TIMEOUT_ON = (FLUSH_TIMEOUT > 0);

    ProducerState_t                          r_state;
    UartData_t [UART_FIFO_MAX_CHARS:1]       r_chars;
    logic [2:0]                              r_count;
    logic [TIMEOUT_WIDTH-1:0]                r_idle_cnt;

    ProducerState_t                          w_next_state;
    logic                                    w_ready;
    logic                                    w_accept;
    logic                                    w_write;
    logic                                    w_timeout_hit;
    logic [TIMEOUT_WIDTH-1:0]                w_idle_next;
    UartFifoData_t                           w_entry;

    // Handshake, write strobe, next state and idle-counter update.
    always_comb begin
        // Ready is held low while reset is asserted so nothing is taken in.
        w_ready       = i_rst && (r_state != PUSH);
        w_accept      = i_byte_valid && w_ready;
        w_write       = (r_state == PUSH) && !i_fifo_full;
        w_timeout_hit = TIMEOUT_ON && (r_state == COLLECT) &&
                        (r_idle_cnt == TIMEOUT_LAST);
        w_next_state  = r_state;
        unique case (r_state)
            IDLE, COLLECT: begin
                if (w_accept) begin
                    // The seventh byte closes the entry even without a last flag.
                    if (i_byte_last || (r_count == LAST_SLOT)) begin
                        w_next_state = PUSH;
                    end else begin
                        w_next_state = COLLECT;
                    end
                end else if (w_timeout_hit) begin
                    w_next_state = PUSH;
                end
            end
            PUSH: begin
                if (w_write) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        // Counter only runs while collecting; it saturates instead of wrapping.
        if ((w_next_state != COLLECT) || w_accept) begin
            w_idle_next = '0;
        end else if (r_idle_cnt != '1) begin
            w_idle_next = r_idle_cnt + 1'b1;
        end else begin
            w_idle_next = r_idle_cnt;
        end
    end

    // State, shift register, byte count and idle counter.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_chars    <= '0;
            r_count    <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_idle_cnt <= w_idle_next;
            if (w_write) begin
                r_chars <= '0;
                r_count <= '0;
            end else if (w_accept) begin
                // Newest byte enters slot 1; the first byte ends up in slot[count].
                r_chars <= {r_chars[UART_FIFO_MAX_CHARS-1:1], i_byte_data};
                r_count <= r_count + 3'd1;
            end
        end
    end

    // Entry is only exposed while it is being offered to the FIFO.
    always_comb begin
        w_entry.length = r_count;
        w_entry.chars  = r_chars;
        o_byte_ready         = w_ready;
        o_fifo_write_request = w_write;
        o_fifo_in_data       = (r_state == PUSH) ? w_entry : '0;
        o_busy               = (r_state != IDLE);
    end

endmodule
